// File: rtl/instr_fetch_pkg.sv
// Shared widths, defaults and the queue entry type for the instruction fetch stage.
package instr_fetch_pkg;

  localparam int ADDR_W      = 16;
  localparam int INSTR_W     = 16;
  localparam int Q_DEPTH_DEF = 2;

  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

  // Width needed to count 0..depth inclusive.
  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// Fetch-to-decode valid/ready channel carrying an instruction word and its address.
interface instr_fetch_if;
  import instr_fetch_pkg::*;

  logic               ir_valid;
  logic [INSTR_W-1:0] ir_data;
  logic [ADDR_W-1:0]  ir_pc;
  logic               ir_ready;

  modport master (output ir_valid, output ir_data, output ir_pc, input ir_ready);
  modport slave  (input ir_valid, input ir_data, input ir_pc, output ir_ready);

endinterface

// File: rtl/instr_fetch_queue.sv
// Show-ahead synchronous FIFO of fetched words; flush empties it in one cycle.
module instr_fetch_queue
  import instr_fetch_pkg::*;
#(
  parameter  int DEPTH = Q_DEPTH_DEF,
  localparam int CNT_W = cnt_width(DEPTH),
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push_i,
  input  fetch_entry_t     entry_i,
  input  logic             pop_i,
  input  logic             flush_i,
  output logic [CNT_W-1:0] occ_o,
  output fetch_entry_t     head_o
);

  fetch_entry_t     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] occ_q, occ_d;
  logic             do_push, do_pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
    return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + 1'b1;
  endfunction

  assign do_push = push_i & ~flush_i;
  assign do_pop  = pop_i & ~flush_i;

  // NOTE: every variable gets a default at the top of always_comb so no path leaves it unassigned (no latch).
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      occ_d    = '0;
    end else begin
      if (do_push) wr_ptr_d = next_ptr(wr_ptr_q);
      if (do_pop)  rd_ptr_d = next_ptr(rd_ptr_q);
      occ_d = occ_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
    end
  end

  // NOTE: storage is deliberately not reset; occupancy alone decides which entries are visible.
  always_ff @(posedge clock) begin
    if (do_push) mem_q[wr_ptr_q] <= entry_i;
  end

  assign occ_o  = occ_q;
  assign head_o = (occ_q == '0) ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: one ROM read per cycle at the PC, credit-limited by the queue, flushed on a taken jump.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter int Q_DEPTH = Q_DEPTH_DEF
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [ADDR_W-1:0]  pc_addr,
  output logic               pc_adv,
  input  logic               jump_taken,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  instr_fetch_if.master      dec
);

  localparam int CNT_W = cnt_width(Q_DEPTH);
  localparam int CRD_W = CNT_W + 1;

  logic              inflight_q, inflight_d;
  logic [ADDR_W-1:0] req_pc_q, req_pc_d;
  logic              post_rst_q;
  logic [CNT_W-1:0]  occ;
  logic [CRD_W-1:0]  credit;
  logic              ir_valid, pop, push, req;
  fetch_entry_t      head, entry;

  // Words already queued plus the one in flight must leave room for the read issued now.
  always_comb begin
    ir_valid   = (occ != '0) & ~reset;
    pop        = ir_valid & dec.ir_ready & ~jump_taken;
    push       = inflight_q & ~jump_taken;
    credit     = {1'b0, occ} + CRD_W'(inflight_q) - CRD_W'(pop);
    req        = ~reset & ~post_rst_q & ~jump_taken & (credit < CRD_W'(Q_DEPTH));
    inflight_d = req;
    req_pc_d   = req ? pc_addr : req_pc_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      inflight_q <= 1'b0;
      req_pc_q   <= '0;
      post_rst_q <= 1'b1;
    end else begin
      inflight_q <= inflight_d;
      req_pc_q   <= req_pc_d;
      post_rst_q <= 1'b0;
    end
  end

  assign entry = '{pc: req_pc_q, instr: imem_rdata};

  instr_fetch_queue #(.DEPTH(Q_DEPTH)) u_queue (
    .clock   (clock),
    .reset   (reset),
    .push_i  (push),
    .entry_i (entry),
    .pop_i   (pop),
    .flush_i (jump_taken),
    .occ_o   (occ),
    .head_o  (head)
  );

  assign imem_req     = req;
  assign imem_addr    = pc_addr;
  assign pc_adv       = req;
  assign dec.ir_valid = ir_valid;
  assign dec.ir_data  = head.instr;
  assign dec.ir_pc    = head.pc;

endmodule
